// File: rtl/mul8_ha_pkg.sv
// Shared constants and helpers for the 8x8 approximate multiplier final adder.
// Row groups are carried as {b,t} pairs; row_val folds one pair into its row value.
package mul8_ha_pkg;

  localparam int ROWS    = 4;
  localparam int ROW_T_W = 9;
  localparam int ROW_B_W = 7;
  localparam int ROW_W   = 10;
  localparam int RAW_W   = 17;
  // Partial sums R0+(R1<<2) reach 1019+4076 = 5095, so they need 13 bits.
  localparam int PART_W  = 13;

  typedef struct packed {
    logic [ROW_B_W-1:0] b;
    logic [ROW_T_W-1:0] t;
  } row_t;

  // R = t + (b << 2); max 511 + 508 = 1019, fits in ROW_W bits.
  function automatic logic [ROW_W-1:0] row_val(input row_t r);
    return {{(ROW_W-ROW_T_W){1'b0}}, r.t}
         + {{(ROW_W-ROW_B_W-2){1'b0}}, r.b, 2'b00};
  endfunction

endpackage

// File: rtl/mul8_ha_pipe_stage.sv
// Generic valid/ready register slice: one entry, full throughput.
// Upstream may load whenever the slot is empty or the slot drains this cycle.
module mul8_ha_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign in_ready  = !r_valid | out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  // Load a new entry (or go empty) whenever the slot is free; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mul8_ha_array_final_adder.sv
// Final adder of the 8x8 approximate multiplier's half-adder array.
// Stage 1 forms two partial sums, stage 2 forms the 17-bit raw sum and
// saturates it to OUT_W bits. Optional macro MUL8_HA_MAC_EN adds a running
// accumulator of the unsaturated raw sums (acc_clr / out_acc ports).
module mul8_ha_array_final_adder
  import mul8_ha_pkg::*;
#(
  parameter int OUT_W = 16
`ifdef MUL8_HA_MAC_EN
  ,
  parameter int ACC_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROW_T_W-1:0] ha_array_0_t,
  input  logic [ROW_B_W-1:0] ha_array_0_b,
  input  logic [ROW_T_W-1:0] ha_array_1_t,
  input  logic [ROW_B_W-1:0] ha_array_1_b,
  input  logic [ROW_T_W-1:0] ha_array_2_t,
  input  logic [ROW_B_W-1:0] ha_array_2_b,
  input  logic [ROW_T_W-1:0] ha_array_3_t,
  input  logic [ROW_B_W-1:0] ha_array_3_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_product,
  output logic               out_ovf
`ifdef MUL8_HA_MAC_EN
  ,
  input  logic               acc_clr,
  output logic [ACC_W-1:0]   out_acc
`endif
);

`ifdef MUL8_HA_MAC_EN
  localparam int S1_W = 2*PART_W + 1;
`else
  localparam int S1_W = 2*PART_W;
`endif
  localparam int S2_W = OUT_W + 1;

  // ---- row values ----
  row_t             w_row  [ROWS];
  logic [ROW_W-1:0] w_rval [ROWS];

  assign w_row[0] = row_t'{b: ha_array_0_b, t: ha_array_0_t};
  assign w_row[1] = row_t'{b: ha_array_1_b, t: ha_array_1_t};
  assign w_row[2] = row_t'{b: ha_array_2_b, t: ha_array_2_t};
  assign w_row[3] = row_t'{b: ha_array_3_b, t: ha_array_3_t};

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      assign w_rval[gi] = row_val(w_row[gi]);
    end
  endgenerate

  // ---- stage 1: pairwise partial sums ----
  logic [PART_W-1:0] w_p01;
  logic [PART_W-1:0] w_p23;
  logic [S1_W-1:0]   w_s1_in_data;
  logic [S1_W-1:0]   w_s1_data;
  logic              w_s1_valid;
  logic              w_s1_in_ready;
  logic              w_s2_in_ready;

  assign w_p01 = PART_W'(w_rval[0]) + (PART_W'(w_rval[1]) << 2);
  assign w_p23 = PART_W'(w_rval[2]) + (PART_W'(w_rval[3]) << 2);

`ifdef MUL8_HA_MAC_EN
  // The clear flag rides with its entry so it applies to that product only.
  assign w_s1_in_data = {acc_clr, w_p23, w_p01};
`else
  assign w_s1_in_data = {w_p23, w_p01};
`endif

  mul8_ha_pipe_stage #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (w_s1_in_ready),
    .in_data   (w_s1_in_data),
    .out_valid (w_s1_valid),
    .out_ready (w_s2_in_ready),
    .out_data  (w_s1_data)
  );

  assign in_ready = w_s1_in_ready;

  // ---- stage 2: raw sum and saturation ----
  logic [PART_W-1:0] w_s1_p01;
  logic [PART_W-1:0] w_s1_p23;
  logic [RAW_W-1:0]  w_sum;
  logic [OUT_W-1:0]  w_sat_product;
  logic              w_sat_ovf;
  logic [S2_W-1:0]   w_s2_data;

  assign w_s1_p01 = w_s1_data[PART_W-1:0];
  assign w_s1_p23 = w_s1_data[2*PART_W-1:PART_W];
  assign w_sum    = RAW_W'(w_s1_p01) + (RAW_W'(w_s1_p23) << 4);

  generate
    if (OUT_W >= RAW_W) begin : g_no_sat
      // Raw sum always fits; overflow cannot happen.
      assign w_sat_ovf     = 1'b0;
      assign w_sat_product = OUT_W'(w_sum);
    end else begin : g_sat
      assign w_sat_ovf     = |w_sum[RAW_W-1:OUT_W];
      assign w_sat_product = w_sat_ovf ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];
    end
  endgenerate

  mul8_ha_pipe_stage #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_s1_valid),
    .in_ready  (w_s2_in_ready),
    .in_data   ({w_sat_ovf, w_sat_product}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_s2_data)
  );

  assign out_ovf     = w_s2_data[S2_W-1];
  assign out_product = w_s2_data[OUT_W-1:0];

`ifdef MUL8_HA_MAC_EN
  // ---- accumulator, advanced in lock-step with stage 2 loads ----
  logic             w_s1_clr;
  logic [ACC_W-1:0] r_acc;

  assign w_s1_clr = w_s1_data[2*PART_W];

  // Load or add the raw (unsaturated) sum as the entry moves into stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_s1_valid && w_s2_in_ready) begin
      r_acc <= w_s1_clr ? ACC_W'(w_sum) : r_acc + ACC_W'(w_sum);
    end
  end

  assign out_acc = r_acc;
`endif

endmodule

// File: tb/tb_mul8_ha_array_final_adder.sv
// Scoreboard bench for mul8_ha_array_final_adder: the driver pushes the
// hand-computed expected result on each accepted beat; a monitor pops and
// compares on every out_valid & out_ready. Define MUL8_HA_MAC_EN to also
// exercise the accumulator.
module tb_mul8_ha_array_final_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  t0 = '0, t1 = '0, t2 = '0, t3 = '0;
  logic [6:0]  b0 = '0, b1 = '0, b2 = '0, b3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_product;
  logic        out_ovf;
`ifdef MUL8_HA_MAC_EN
  logic        acc_clr = 1'b0;
  logic [31:0] out_acc;
`endif

  mul8_ha_array_final_adder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_t (t0),
    .ha_array_0_b (b0),
    .ha_array_1_t (t1),
    .ha_array_1_b (b1),
    .ha_array_2_t (t2),
    .ha_array_2_b (b2),
    .ha_array_3_t (t3),
    .ha_array_3_b (b3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .out_ovf      (out_ovf)
`ifdef MUL8_HA_MAC_EN
    ,
    .acc_clr      (acc_clr),
    .out_acc      (out_acc)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [15:0] p;
    logic        o;
    logic [31:0] acc;
    logic        use_acc;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: compare every handshaken output against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(out_product), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          $display("OUT cyc=%0d product=%0d ovf=%0b exp_product=%0d exp_ovf=%0b",
                   cyc, out_product, out_ovf, e.p, e.o);
          check("product", 32'(out_product), 32'(e.p));
          check("ovf", 32'(out_ovf), 32'(e.o));
`ifdef MUL8_HA_MAC_EN
          if (e.use_acc) check("acc", out_acc, e.acc);
`endif
        end
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Drive one beat, wait (bounded) for acceptance, record the expectation.
  task automatic send(input logic [35:0] tv, input logic [27:0] bv, input logic clr,
                      input logic [15:0] ep, input logic eo,
                      input logic [31:0] ea, input logic ua);
    int  waited;
    bit  ok;
    waited = 0;
    ok = 1'b0;
    {t3, t2, t1, t0} = tv;
    {b3, b2, b1, b0} = bv;
`ifdef MUL8_HA_MAC_EN
    acc_clr = clr;
`endif
    in_valid = 1'b1;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        waited++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back('{p: ep, o: eo, acc: ea, use_acc: ua});
      $display("IN  cyc=%0d t={%0d,%0d,%0d,%0d} b={%0d,%0d,%0d,%0d} clr=%0b exp=%0d",
               cyc, t3, t2, t1, t0, b3, b2, b1, b0, clr, ep);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int n0;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(out_product), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1. Zero beat and latency
    send(36'd0, 28'd0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    drain();

    // 2. Single bits and a full row
    send({9'd0, 9'd0, 9'd0, 9'd1},        28'd0,                       1'b0, 16'd1,     1'b0, 32'd0, 1'b0);
    send(36'd0,                           {7'h40, 7'd0, 7'd0, 7'd0},   1'b0, 16'd16384, 1'b0, 32'd0, 1'b0);
    send({9'd0, 9'h100, 9'd0, 9'd0},      28'd0,                       1'b0, 16'd4096,  1'b0, 32'd0, 1'b0);
    send({9'd0, 9'd0, 9'd0, 9'h1FF},      {7'd0, 7'd0, 7'd0, 7'h7F},   1'b0, 16'd1019,  1'b0, 32'd0, 1'b0);
    send(36'd0,                           {7'd0, 7'd0, 7'h08, 7'd0},   1'b0, 16'd128,   1'b0, 32'd0, 1'b0);
    // 3. Saturation and its boundary
    send({9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 1'b0, 16'd65535, 1'b1, 32'd0, 1'b0);
    send({9'h1FF, 9'd0, 9'd0, 9'h03F},    {7'h7F, 7'd0, 7'h10, 7'd0},  1'b0, 16'd65535, 1'b0, 32'd0, 1'b0);
    send({9'h1FF, 9'd0, 9'd0, 9'h040},    {7'h7F, 7'd0, 7'h10, 7'd0},  1'b0, 16'd65535, 1'b1, 32'd0, 1'b0);
    drain();

    // 4. Back-pressure: two accepted, third held, then three consecutive outputs
    out_ready = 1'b0;
    n0 = pop_cyc.size();
    send({9'd0, 9'd0, 9'd0, 9'd1}, 28'd0, 1'b0, 16'd1, 1'b0, 32'd0, 1'b0);
    send({9'd0, 9'd0, 9'd1, 9'd0}, 28'd0, 1'b0, 16'd4, 1'b0, 32'd0, 1'b0);
    fork
      send({9'd0, 9'd1, 9'd0, 9'd0}, 28'd0, 1'b0, 16'd16, 1'b0, 32'd0, 1'b0);
      begin
        repeat (4) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_hold_product", 32'(out_product), 32'd1);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();
    if (pop_cyc.size() >= n0 + 3) begin
      check("consec_1_2", 32'(pop_cyc[n0+1] - pop_cyc[n0]), 32'd1);
      check("consec_2_3", 32'(pop_cyc[n0+2] - pop_cyc[n0+1]), 32'd1);
    end else begin
      check("consec_count", 32'(pop_cyc.size() - n0), 32'd3);
    end

    // 5. Reset with two entries in flight
    out_ready = 1'b0;
    send({9'd0, 9'd0, 9'd0, 9'd7}, 28'd0, 1'b0, 16'd7, 1'b0, 32'd0, 1'b0);
    send({9'd0, 9'd0, 9'd0, 9'd9}, 28'd0, 1'b0, 16'd9, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_product", 32'(out_product), 32'd0);
    check("midrst_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    n0 = pop_cyc.size();
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("no_stale_out", 32'(pop_cyc.size() - n0), 32'd0);
    @(posedge clk);
    #1;

    // Post-reset sanity: pipeline still works
    send({9'd0, 9'd0, 9'd0, 9'd3}, {7'd0, 7'd0, 7'd0, 7'd1}, 1'b0, 16'd7, 1'b0, 32'd0, 1'b0);
    drain();

`ifdef MUL8_HA_MAC_EN
    // 6. Accumulator
    send({9'd0, 9'd0, 9'd0, 9'd100}, 28'd0, 1'b1, 16'd100, 1'b0, 32'd100, 1'b1);
    send({9'd0, 9'd0, 9'd0, 9'd200}, 28'd0, 1'b0, 16'd200, 1'b0, 32'd300, 1'b1);
    send({9'd0, 9'd0, 9'd0, 9'd300}, 28'd0, 1'b0, 16'd300, 1'b0, 32'd600, 1'b1);
    send({9'd0, 9'd0, 9'd0, 9'd5},   28'd0, 1'b1, 16'd5,   1'b0, 32'd5,   1'b1);
    drain();
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
